// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit full subtractor: difference and borrow for x - y - bor_in.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bor_in,
    output logic d,
    output logic bor_out
);

    assign d       = x ^ y ^ bor_in;
    assign bor_out = (~x & (y ^ bor_in)) | (y & bor_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor (LSB first, one bit per clock) producing a-b mod 2^WIDTH and a borrow.
// Optional feature: define SERIAL_SUB_BORROW_IN_EN to add a borrow_in port (result a-b-borrow_in).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic             bor;
    logic [CNT_W-1:0] cnt;
    logic             bor_init;
    logic             d;
    logic             bor_next;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign bor_init = borrow_in;
`else
    assign bor_init = 1'b0;
`endif

    fs_cell u_fs_cell (
        .x       (x_sr[0]),
        .y       (y_sr[0]),
        .bor_in  (bor),
        .d       (d),
        .bor_out (bor_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_sr       <= '0;
            y_sr       <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_sr  <= a;
                        y_sr  <= b;
                        bor   <= bor_init;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at diff[0].
                    diff <= {d, diff[WIDTH-1:1]};
                    x_sr <= x_sr >> 1;
                    y_sr <= y_sr >> 1;
                    bor  <= bor_next;
                    if (cnt == LAST_BIT) begin
                        borrow_out <= bor_next;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend (x); captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend (y); captured on accepted start.
REQ-007 Port: busy  output  1  high while a subtraction is in progress (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse when diff/borrow_out become valid.
REQ-009 Port: diff  output  WIDTH  result a-b mod 2^WIDTH; held stable until next accepted start.
REQ-010 Port: borrow_out  output  1  final borrow (1 when a<b unsigned, plus borrow_in if enabled); held with diff.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE: start=1 SHALL load a and b into shift registers, clear the borrow flop (or load borrow_in, see REQ-024), clear the bit counter, and move to RUN.
REQ-013 RUN: each cycle SHALL process one bit, LSB first: d = x^y^bor, bor_next = (~x&(y^bor)) | (y&bor).
REQ-014 RUN: d SHALL shift into diff from the MSB end; the operand registers SHALL shift right by one.
REQ-015 RUN: the counter SHALL count 0..WIDTH-1; after bit WIDTH-1 the FSM SHALL move to DONE.
REQ-016 DONE: done=1 for exactly one cycle, borrow_out = final borrow; the FSM then returns to IDLE.
REQ-017 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH.
REQ-018 busy SHALL be 1 in RUN only.
REQ-019 start SHALL be ignored in RUN and DONE; back-to-back start in the IDLE cycle after DONE SHALL be accepted.
REQ-020 Between operations, diff and borrow_out SHALL hold their last results; in RUN diff holds partial shift contents and is not valid.

Reset
REQ-021 rst=1 at any edge SHALL force IDLE and clear the counter, borrow, operand registers, diff, borrow_out, busy and done to 0.
REQ-022 rst asserted mid-RUN SHALL abort the operation; no done pulse is produced for it.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SERIAL_SUB_BORROW_IN_EN defined, the block SHALL add port borrow_in (input, 1 bit), captured on accepted start as the initial borrow (result a-b-borrow_in).
REQ-025 Without SERIAL_SUB_BORROW_IN_EN, the port SHALL be absent and the initial borrow SHALL be 0.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The per-bit logic (x, y, bor in -> d, bor_next) SHALL be a combinational sub-module fs_cell, instantiated once.
REQ-028 The counter width SHALL be $clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-029 a=0x35, b=0x12, start for 1 cycle -> busy for 8 cycles, then done pulse, diff=0x23, borrow_out=0.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-031 start pulsed at RUN cycle 3 with a=0x01, b=0x01 -> ignored; first result (a=0x35, b=0x12) completes unchanged at 0x23.
REQ-032 rst asserted at RUN cycle 4 -> next cycle: IDLE, all outputs 0, no done pulse; new start with a=0x80, b=0x7F -> diff=0x01, borrow_out=0.
REQ-033 With SERIAL_SUB_BORROW_IN_EN: a=0x10, b=0x01, borrow_in=1 -> diff=0x0E, borrow_out=0; a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
REQ-034 Random a and b (1000 operations, back-to-back) -> every diff/borrow_out matches the reference model {borrow,diff} = a-b; each done arrives exactly WIDTH+1 cycles after start.
